// File: rtl/slave_ram_pkg.sv
// Shared types and constants for the slave_ram bus endpoint.
package slave_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } slave_ram_state_t;

  localparam logic       CMD_READ  = 1'b0;
  localparam logic       CMD_WRITE = 1'b1;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/slave_ram_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that perturbs the wait count.
// Only built when SLAVE_RAM_RANDOM_WAIT_EN is defined.
`ifdef SLAVE_RAM_RANDOM_WAIT_EN
module lfsr8
  import slave_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= LFSR_SEED;
    else if (en)
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
  end

endmodule
`endif

// File: rtl/slave_ram.sv
// Crossbar slave-port memory endpoint: one request at a time, wait states, ack pulse.
// SLAVE_RAM_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per request.
module slave_ram
  import slave_ram_pkg::*;
#(
  parameter int N           = 31,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [N:0]   addr,
  input  logic         cmd,
  input  logic [N:0]   wdata,
  output logic         ack,
  output logic [N:0]   rdata
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 5);

  slave_ram_state_t        state, next_state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        load_cnt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    cmd_q;
  logic [N:0]              wdata_q;
  logic                    accept;
  logic                    ack_d;
  logic                    mem_we;
  logic                    rd_en;
  logic [N:0]              mem [2**DEPTH_LOG2];

  // Slave-select bit, byte offset and aliasing bits take no part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[N:DEPTH_LOG2+2], addr[1:0]};

  assign accept = (state == IDLE) && req;

`ifdef SLAVE_RAM_RANDOM_WAIT_EN
  logic [7:0] lfsr_state;
  logic       unused_lfsr_bits;

  lfsr8 u_lfsr8 (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .state (lfsr_state)
  );

  assign unused_lfsr_bits = ^lfsr_state[7:2];
  assign load_cnt = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr_state[1:0]);
`else
  assign load_cnt = CNT_W'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (load_cnt == '0) ? ACK : WAIT;
      WAIT: if (cnt == CNT_W'(1)) next_state = ACK;
      ACK:  next_state = DONE;
      DONE: if (!req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ack_d  = (next_state == ACK);
    mem_we = (state == ACK) && (cmd_q == CMD_WRITE);
    rd_en  = (state == ACK) && (cmd_q == CMD_READ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      idx_q   <= '0;
      cmd_q   <= CMD_READ;
      wdata_q <= '0;
      ack     <= 1'b0;
    end else begin
      ack <= ack_d;
      if (accept) begin
        cnt     <= load_cnt;
        idx_q   <= addr[DEPTH_LOG2+1:2];
        cmd_q   <= cmd;
        wdata_q <= wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Memory contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= mem[idx_q];
  end

endmodule

// File: tb/tb_slave_ram.sv
// Self-checking bench for slave_ram: vector table, corner sequences, random traffic vs. a word-array model.
module tb_slave_ram;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        cmd;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [int];
  logic [31:0] rd_m;

  typedef struct {
    logic        c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  slave_ram #(.N(31), .DEPTH_LOG2(8), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .addr  (addr),
    .cmd   (cmd),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  // One full transaction; scrambles the bus after acceptance to prove it is ignored.
  task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d,
                     input string nm, output logic [31:0] rd_obs);
    int lat;
    bit seen;
    @(posedge clk); #1;
    req = 1'b1; cmd = c; addr = a; wdata = d;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        cmd = ~c; addr = $urandom; wdata = $urandom;
      end
      if (ack) seen = 1;
    end
    if (!seen) lat = 99;
`ifdef SLAVE_RAM_RANDOM_WAIT_EN
    chk_range({nm, " ack latency"}, lat, W + 1, W + 4);
`else
    chk({nm, " ack latency"}, 32'(lat), 32'(W + 1));
`endif
    if (c) mem_m[widx(a)] = d;
    else if (mem_m.exists(widx(a))) rd_m = mem_m[widx(a)];
    @(posedge clk); #1;
    chk({nm, " ack single pulse"}, 32'(ack), 32'd0);
    chk({nm, " rdata"}, rdata, rd_m);
    rd_obs = rdata;
    req = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] obs;
    logic [31:0] pool [8];
    int          n;

    reset = 1'b1; req = 1'b0; cmd = 1'b0; addr = '0; wdata = '0;
    rd_m = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle ack", 32'(ack), 32'd0);
      chk("idle rdata", rdata, 32'd0);
    end

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'h0000_0001, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0001});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'hA5A5_0001, 32'h0000_0001});
    vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h0,         32'hA5A5_0001});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h0000_0011, 32'hA5A5_0001});
    vecs.push_back('{1'b1, 32'h0000_0024, 32'h0000_0022, 32'hA5A5_0001});
    vecs.push_back('{1'b0, 32'h0000_0023, 32'h0,         32'h0000_0011});
    vecs.push_back('{1'b0, 32'h8000_0424, 32'h0,         32'h0000_0022});
    foreach (vecs[i]) begin
      txn(vecs[i].c, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i), obs);
      chk($sformatf("vec%0d table rdata", i), obs, vecs[i].exp);
    end

    // Held request: exactly one ack, then a one-cycle gap re-arms the slave.
    @(posedge clk); #1;
    req = 1'b1; cmd = 1'b1; addr = 32'h30; wdata = 32'h77;
    n = 0;
    for (int i = 0; i < W + 1 + 20; i++) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    chk("held req ack count", 32'(n), 32'd1);
    mem_m[widx(32'h30)] = 32'h77;
    req = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; cmd = 1'b0; addr = 32'h30;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clk); #1;
      if (ack) n = i;
    end
`ifdef SLAVE_RAM_RANDOM_WAIT_EN
    chk_range("rearm ack latency", n, W + 1, W + 4);
`else
    chk("rearm ack latency", 32'(n), 32'(W + 1));
`endif
    rd_m = 32'h77;
    @(posedge clk); #1;
    chk("rearm rdata", rdata, 32'h77);
    req = 1'b0;

    // Reset while a write waits: no ack, no commit.
    @(posedge clk); #1;
    req = 1'b1; cmd = 1'b1; addr = 32'h20; wdata = 32'h55;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("async reset ack", 32'(ack), 32'd0);
    chk("async reset rdata", rdata, 32'd0);
    rd_m = '0;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    chk("aborted write ack count", 32'(n), 32'd0);
    txn(1'b0, 32'h20, 32'h0, "post-reset read", obs);
    chk("aborted write not committed", obs, 32'h11);

    // Random traffic over a small address pool, all pre-written.
    for (int i = 0; i < 8; i++) begin
      pool[i] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      txn(1'b1, pool[i], $urandom, "rand fill", obs);
    end
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a;
      logic        c;
      a = pool[$urandom_range(0, 7)];
      a = a | {1'($urandom), 21'($urandom), 8'h0, 2'($urandom)};
      c = ($urandom_range(0, 3) == 0);
      txn(c, a, $urandom, $sformatf("rand%0d", i), obs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
